// File: rtl/arch_defs_pkg.sv
// Architecture-wide definitions shared by the RAM access path.
// Holds the default datapath widths, the arbiter state and owner encodings,
// and the arbitration decision so it can be reused by other requesters.
package arch_defs_pkg;

    localparam int ARCH_DATA_WIDTH = 8;
    localparam int ARCH_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU,
        OWNER_LDR
    } arb_owner_t;

    // The CPU has fixed priority. The loader wins when it is the only
    // requester, or when it has been passed over often enough to be starved.
    function automatic arb_owner_t arb_pick(
        input logic cpu_req,
        input logic ldr_req,
        input logic ldr_starved
    );
        arb_owner_t winner;
        winner = OWNER_CPU;
        if (ldr_req && (!cpu_req || ldr_starved)) begin
            winner = OWNER_LDR;
        end
        return winner;
    endfunction

endpackage

// File: rtl/ram_access_arbiter.sv
// Purpose     : shares the single-port main RAM between the CPU and the program/debug loader.
// Latency     : fixed 3-cycle transaction; req seen in IDLE at cycle N -> ack in cycle N+2.
// Backpressure: a requester holds req until its one-cycle ack; the loser simply waits for the next IDLE.
//
// Ports
//   clk, reset                       clock and synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU request; cpu_ack/cpu_rdata completion and read data
//   ldr_req/we/addr/wdata            loader request; ldr_ack/ldr_rdata completion and read data
//   ram_we/addr/wdata, ram_rdata     RAM port; ram_rdata has a 1-cycle synchronous latency
//   busy                             high while a transaction is in ACCESS or RESP
//   owner                            0 = CPU, 1 = loader; owner of the current or last grant
module ram_access_arbiter
    import arch_defs_pkg::*;
#(
    parameter int DATA_WIDTH   = ARCH_DATA_WIDTH,
    parameter int ADDR_WIDTH   = ARCH_ADDR_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] ldr_rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic                  busy,
    output logic                  owner
);

    // Counter must be able to hold STARVE_LIMIT itself (saturation value).
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t            state_q,      state_d;
    arb_owner_t            owner_q,      owner_d;
    logic                  we_q,         we_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;

    arb_owner_t            winner;

    // ------------------------------------------------------------------
    // Next-state, request latch and starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        starve_cnt_d = starve_cnt_q;
        winner       = arb_pick(cpu_req, ldr_req, starve_cnt_q == CNT_MAX);

        unique case (state_q)
            ARB_IDLE: begin
                if (cpu_req || ldr_req) begin
                    state_d = ARB_ACCESS;
                    owner_d = winner;
                    // Inline 2:1 request mux; the latched copy decouples the
                    // RAM port from requester inputs for the rest of the
                    // transaction.
                    if (winner == OWNER_LDR) begin
                        we_d         = ldr_we;
                        addr_d       = ldr_addr;
                        wdata_d      = ldr_wdata;
                        starve_cnt_d = '0;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        if (ldr_req && (starve_cnt_q != CNT_MAX)) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
                // A loader that is not asking has nothing to be starved of.
                if (!ldr_req) begin
                    starve_cnt_d = '0;
                end
            end
            ARB_ACCESS: state_d = ARB_RESP;
            ARB_RESP:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode: only state and latched values, never the req inputs.
    // ------------------------------------------------------------------
    always_comb begin
        ram_we    = (state_q == ARB_ACCESS) && we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        busy      = (state_q != ARB_IDLE);
        owner     = (owner_q == OWNER_LDR);
        cpu_ack   = (state_q == ARB_RESP) && (owner_q == OWNER_CPU);
        ldr_ack   = (state_q == ARB_RESP) && (owner_q == OWNER_LDR);
        // RAM read data is only forwarded to the acknowledged requester so
        // the rdata outputs read as zero whenever no response is in flight.
        cpu_rdata = cpu_ack ? ram_rdata : '0;
        ldr_rdata = ldr_ack ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 1-cycle synchronous RAM.
// Inputs are driven and outputs sampled on the falling edge.
module tb_ram_access_arbiter;
    import arch_defs_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic       cpu_ack, ldr_ack, ram_we, busy, owner;
    logic [7:0] cpu_rdata, ldr_rdata, ram_addr, ram_wdata, ram_rdata;

    int checks = 0;
    int passes = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    ram_access_arbiter #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (8),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .ldr_req  (ldr_req),
        .ldr_we   (ldr_we),
        .ldr_addr (ldr_addr),
        .ldr_wdata(ldr_wdata),
        .ldr_ack  (ldr_ack),
        .ldr_rdata(ldr_rdata),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .busy     (busy),
        .owner    (owner)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a falling edge with the arbiter in IDLE; returns at the
    // falling edge of the IDLE cycle that follows RESP.
    task automatic txn(input string tag, input bit is_ldr, input bit we,
                       input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rdata);
        if (is_ldr) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        @(negedge clk);                           // ACCESS
        chk({tag, "_acc_busy"},  busy, 1);
        chk({tag, "_acc_we"},    ram_we, we);
        chk({tag, "_acc_addr"},  ram_addr, addr);
        chk({tag, "_acc_owner"}, owner, is_ldr);
        chk({tag, "_acc_noack"}, {cpu_ack, ldr_ack}, 0);
        if (we) chk({tag, "_acc_wdata"}, ram_wdata, wdata);
        @(negedge clk);                           // RESP
        chk({tag, "_resp_ack"}, {cpu_ack, ldr_ack}, is_ldr ? 2'b01 : 2'b10);
        chk({tag, "_resp_wenone"}, ram_we, 0);
        if (!we) chk({tag, "_resp_rdata"}, is_ldr ? ldr_rdata : cpu_rdata, exp_rdata);
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        @(negedge clk);                           // IDLE
        chk({tag, "_idle_ack"},  {cpu_ack, ldr_ack}, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] prog [4];
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",  busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ack",   {cpu_ack, ldr_ack}, 0);
        chk("rst_we",    ram_we, 0);
        chk("rst_addr",  ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        reset = 1'b0;

        // 1. CPU write then read back
        txn("t1_cpu_wr", 0, 1, 8'h0E, 8'h0A, 8'h00);
        txn("t1_cpu_rd", 0, 0, 8'h0E, 8'h00, 8'h0A);

        // 2. Loader-only write then read back
        txn("t2_ldr_wr", 1, 1, 8'h03, 8'h55, 8'h00);
        txn("t2_ldr_rd", 1, 0, 8'h03, 8'h00, 8'h55);

        // 3. Simultaneous request: CPU first, loader on the next IDLE
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h0E;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h03;
        @(negedge clk);
        chk("t3_acc1_owner", owner, 0);
        @(negedge clk);
        chk("t3_resp1_ack",   {cpu_ack, ldr_ack}, 2'b10);
        chk("t3_resp1_rdata", cpu_rdata, 8'h0A);
        chk("t3_starve1",     dut.starve_cnt_q, 1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("t3_idle_ack", {cpu_ack, ldr_ack}, 0);
        @(negedge clk);
        chk("t3_acc2_owner", owner, 1);
        chk("t3_acc2_ack",   {cpu_ack, ldr_ack}, 0);
        @(negedge clk);
        chk("t3_resp2_ack",   {cpu_ack, ldr_ack}, 2'b01);
        chk("t3_resp2_rdata", ldr_rdata, 8'h55);
        chk("t3_starve2",     dut.starve_cnt_q, 0);
        ldr_req = 1'b0;
        @(negedge clk);
        chk("t3_idle2_ack", {cpu_ack, ldr_ack}, 0);

        // 4. CPU held continuously with loader pending: 4 CPU grants, then loader
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h0E;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h03;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t4_acc%0d_owner", i), owner, (i == 4) ? 1 : 0);
            @(negedge clk);
            chk($sformatf("t4_resp%0d_ack", i), {cpu_ack, ldr_ack}, (i == 4) ? 2'b01 : 2'b10);
            chk($sformatf("t4_resp%0d_starve", i), dut.starve_cnt_q, (i == 4) ? 0 : i + 1);
            if (i == 4) begin
                chk("t4_ldr_rdata", ldr_rdata, 8'h55);
                cpu_req = 1'b0;
                ldr_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t4_idle%0d_busy", i), busy, 0);
        end

        // 5. Reset during ACCESS of a CPU read drops it with no ack
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h0E;
        @(negedge clk);
        chk("t5_acc_busy", busy, 1);
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("t5_state", dut.state_q, ARB_IDLE);
        chk("t5_ack",   {cpu_ack, ldr_ack}, 0);
        chk("t5_busy",  busy, 0);
        chk("t5_we",    ram_we, 0);
        chk("t5_addr",  ram_addr, 0);
        chk("t5_rdata", {cpu_rdata, ldr_rdata}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_noack_after", {cpu_ack, ldr_ack}, 0);
        txn("t5_reissue", 0, 0, 8'h0E, 8'h00, 8'h0A);

        // 6. Loader fills a small program image, then the CPU reads it back
        prog[0] = 8'h0A; prog[1] = 8'hC3; prog[2] = 8'h0F; prog[3] = 8'hF0;
        for (int i = 0; i < 4; i++)
            txn($sformatf("t6_ldr_wr%0d", i), 1, 1, 8'h20 + 8'(i), prog[i], 8'h00);
        for (int i = 0; i < 4; i++)
            txn($sformatf("t6_cpu_rd%0d", i), 0, 0, 8'h20 + 8'(i), 8'h00, prog[i]);
        txn("t6_outm_wr", 0, 1, 8'hFF, 8'h0A, 8'h00);
        txn("t6_outm_rd", 1, 0, 8'hFF, 8'h00, 8'h0A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
